// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types and constants for the RLE pipeline stages
package rle_pkg;
  localparam int RLE_DATA_W  = 32;
  localparam int RLE_CNT_W   = 8;
  localparam int RLE_CNT_MAX = (1 << RLE_CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rle_state_e;

  // Pair layout shared with the packer stage
  typedef struct packed {
    logic [RLE_DATA_W-1:0] data;
    logic [RLE_CNT_W-1:0]  count;
    logic                  last;
  } rle_pair_t;
endpackage

// File: rtl/rle_encoder_if.sv
// rtl/rle_encoder_if.sv - word input and pair output handshakes of the run-length encoder
interface rle_encoder_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/rle_out_reg.sv
// rtl/rle_out_reg.sv - single-entry valid/ready holding register for encoded pairs
module rle_out_reg #(
  parameter int W = 41
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         slot_free
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Producer may only load while the slot is free, so a held pair is never overwritten
  assign slot_free = !valid_q || ready;

  always_comb begin
    valid_d = valid_q && !ready;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - collapses runs of identical colour words into (word, count, last) pairs
module rle_encoder
  import rle_pkg::*;
#(
  parameter int DATA_W = RLE_DATA_W,
  parameter int CNT_W  = RLE_CNT_W
) (
  input logic          clock,
  input logic          reset,
  rle_encoder_if.slave bus
);
  localparam int               PAIR_W  = DATA_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] run_data_q, run_data_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              slot_free, xfer, extend;
  logic              emit, emit_last;
  logic [DATA_W-1:0] emit_data;
  logic [CNT_W-1:0]  emit_cnt;
  logic [PAIR_W-1:0] out_pair;

  assign bus.in_ready = (state_q != ST_FLUSH) && slot_free;
  assign xfer         = bus.in_valid && bus.in_ready;
  // A full run closes exactly like a colour change, which splits saturated runs
  assign extend       = (bus.in_data == run_data_q) && (run_cnt_q != CNT_MAX);

  always_comb begin
    state_d    = state_q;
    run_data_d = run_data_q;
    run_cnt_d  = run_cnt_q;
    emit       = 1'b0;
    emit_data  = run_data_q;
    emit_cnt   = run_cnt_q;
    emit_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (bus.in_last) begin
            emit      = 1'b1;
            emit_data = bus.in_data;
            emit_cnt  = CNT_W'(1);
            emit_last = 1'b1;
          end else begin
            run_data_d = bus.in_data;
            run_cnt_d  = CNT_W'(1);
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (extend) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
            if (bus.in_last) begin
              emit      = 1'b1;
              emit_cnt  = run_cnt_q + CNT_W'(1);
              emit_last = 1'b1;
              state_d   = ST_IDLE;
            end
          end else begin
            emit       = 1'b1;
            run_data_d = bus.in_data;
            run_cnt_d  = CNT_W'(1);
            if (bus.in_last) state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_data_q <= '0;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      run_data_q <= run_data_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  rle_out_reg #(.W(PAIR_W)) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (emit),
    .load_data ({emit_data, emit_cnt, emit_last}),
    .ready     (bus.out_ready),
    .valid     (bus.out_valid),
    .data      (out_pair),
    .slot_free (slot_free)
  );

  assign {bus.out_data, bus.out_count, bus.out_last} = out_pair;
endmodule
